// File: rtl/ps2_key_event_rx_pkg.sv
// rtl/ps2_key_event_rx_pkg.sv - shared constants, decoder states and event layout for the PS/2 key event receiver
package ps2_key_event_rx_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam int FRAME_BITS  = 11;
    localparam int EV_CODE_LSB = 0;
    localparam int EV_BRK_BIT  = 8;
    localparam int EV_EXT_BIT  = 9;
    localparam int EV_W        = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_t;

    function automatic logic [EV_W-1:0] pack_event(input logic ext, input logic brk,
                                                   input logic [7:0] code);
        return {ext, brk, code};
    endfunction

endpackage

// File: rtl/ps2_key_event_rx_frame_rx.sv
// rtl/ps2_key_event_rx_frame_rx.sv - PS/2 line synchroniser, 11-bit frame assembler, timeout resync and frame check
module ps2_key_event_rx_frame_rx
    import ps2_key_event_rx_pkg::*;
#(
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       i_clrn,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]    r_clk_sync;
    logic [2:0]    r_data_sync;
    logic          r_clk_prev;
    logic [3:0]    r_bit_cnt;
    logic [9:0]    r_shift;
    logic [TW-1:0] r_to_cnt;
    logic          r_byte_valid;
    logic [7:0]    r_byte;
    logic          r_frame_err;

    logic w_fall;
    logic w_bit;
    logic w_last;
    logic w_frame_ok;

    assign w_fall = r_clk_prev & ~r_clk_sync[2];
    assign w_bit  = r_data_sync[2];
    assign w_last = w_fall && (r_bit_cnt == 4'(FRAME_BITS - 1));
    // After ten shifts: [0]=start, [8:1]=D0..D7, [9]=parity; the stop bit is on the line now
    assign w_frame_ok = ~r_shift[0] & w_bit & (^r_shift[9:1]);

    always_ff @(posedge clk) begin
        if (!i_clrn) begin
            r_clk_sync   <= 3'b111;
            r_data_sync  <= 3'b111;
            r_clk_prev   <= 1'b1;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_to_cnt     <= '0;
            r_byte_valid <= 1'b0;
            r_byte       <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_clk_sync   <= {r_clk_sync[1:0], i_ps2_clk};
            r_data_sync  <= {r_data_sync[1:0], i_ps2_data};
            r_clk_prev   <= r_clk_sync[2];
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                if (w_last) begin
                    r_bit_cnt <= '0;
                    if (w_frame_ok) begin
                        r_byte_valid <= 1'b1;
                        r_byte       <= r_shift[8:1];
                    end else begin
                        r_frame_err  <= 1'b1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    r_shift   <= {w_bit, r_shift[9:1]};
                end
            end else if (r_bit_cnt != '0) begin
                // A stalled partial frame is abandoned silently so the next start bit realigns
                if (r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    r_bit_cnt <= '0;
                    r_to_cnt  <= '0;
                end else begin
                    r_to_cnt  <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign o_byte_valid = r_byte_valid;
    assign o_byte       = r_byte;
    assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/ps2_key_event_rx.sv
// rtl/ps2_key_event_rx.sv - PS/2 keyboard receiver with E0/F0 prefix decoding, event FIFO and press counter
module ps2_key_event_rx
    import ps2_key_event_rx_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 5000,
    parameter int CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    input  logic                     nextdata_n,
    input  logic                     ovf_clr,
    output logic [7:0]               data,
    output logic                     key_ext,
    output logic                     key_break,
    output logic                     ready,
    output logic                     overflow,
    output logic                     frame_err,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         press_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic            w_byte_valid;
    logic [7:0]      w_byte;

    dec_state_t      r_state;
    dec_state_t      w_state_nxt;
    logic            w_emit;
    logic            w_ev_ext;
    logic            w_ev_brk;

    logic [EV_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic [CNT_W-1:0] r_press;

    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [EV_W-1:0] w_head;

    ps2_key_event_rx_frame_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_rx (
        .clk          (clk),
        .i_clrn       (clrn),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_byte_valid (w_byte_valid),
        .o_byte       (w_byte),
        .o_frame_err  (frame_err)
    );

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_ev_ext    = 1'b0;
        w_ev_brk    = 1'b0;
        if (w_byte_valid) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_byte == PS2_EXT)      w_state_nxt = ST_EXT;
                    else if (w_byte == PS2_BRK) w_state_nxt = ST_BRK;
                    else                        w_emit      = 1'b1;
                end
                ST_EXT: begin
                    if (w_byte == PS2_BRK)      w_state_nxt = ST_EXT_BRK;
                    else if (w_byte != PS2_EXT) begin
                        w_emit      = 1'b1;
                        w_ev_ext    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (w_byte == PS2_EXT)      w_state_nxt = ST_EXT_BRK;
                    else if (w_byte != PS2_BRK) begin
                        w_emit      = 1'b1;
                        w_ev_brk    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    if ((w_byte != PS2_EXT) && (w_byte != PS2_BRK)) begin
                        w_emit      = 1'b1;
                        w_ev_ext    = 1'b1;
                        w_ev_brk    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = ~nextdata_n & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign w_push  = w_emit & (~w_full | w_pop);
    assign w_drop  = w_emit & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= pack_event(w_ev_ext, w_ev_brk, w_byte);
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_press    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
            if (w_drop)       r_overflow <= 1'b1;
            else if (ovf_clr) r_overflow <= 1'b0;
            if (w_push && !w_ev_brk) r_press <= r_press + 1'b1;
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign data        = w_empty ? 8'h00 : w_head[EV_CODE_LSB +: 8];
    assign key_ext     = ~w_empty & w_head[EV_EXT_BIT];
    assign key_break   = ~w_empty & w_head[EV_BRK_BIT];
    assign ready       = ~w_empty;
    assign overflow    = r_overflow;
    assign fifo_count  = r_count;
    assign press_count = r_press;

endmodule
